// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: I/O window register offsets and the STATUS
// register bit layout used by the bus I/O target.
package cpu_pkg;

    typedef enum logic [1:0] {
        IO_DATA   = 2'd0,
        IO_STATUS = 2'd1,
        IO_SW     = 2'd2,
        IO_DIV    = 2'd3
    } io_off_t;

    // STATUS layout for an 8-bit word: {overflow, full, empty, 2'b0, count[2:0]}
    localparam int STAT_OVF   = 7;
    localparam int STAT_FULL  = 6;
    localparam int STAT_EMPTY = 5;
    localparam int STAT_CNT_W = 3;

endpackage

// File: rtl/bus_io_target_sync_fifo.sv
// Small synchronous FIFO with an explicit occupancy counter; a push into a
// full FIFO only lands when a pop frees the head slot on the same edge.
module sync_fifo #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WORD_W-1:0]            din,
    output logic [WORD_W-1:0]            dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              do_push;
    logic              do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; only slots between the pointers are ever read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/bus_io_target.sv
// Memory-mapped I/O target: decodes a 4-word window on the shared bus, queues
// DATA writes into a FIFO and drains them to the display at a programmable pace.
module bus_io_target
    import cpu_pkg::*;
#(
    parameter int          WORD_W  = 8,
    parameter int          OP_W    = 3,
    parameter int unsigned BASE    = 'h1C,
    parameter int          DEPTH   = 4,
    parameter int          DIV_RST = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     CS,
    input  logic                     R_NW,
    input  logic [WORD_W-OP_W-1:0]   addr,
    inout  wire  [WORD_W-1:0]        sysbus,
    input  logic [WORD_W-1:0]        switches,
    output logic [WORD_W-1:0]        display,
    output logic                     irq_empty
);

    localparam int                ADDR_W = WORD_W - OP_W;
    localparam int                CNT_W  = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

    logic              hit;
    io_off_t           off;
    logic              wr_en;
    logic              rd_en;
    logic              push;
    logic              div_wr;
    logic              status_rd;

    logic              pop;
    logic              ovf_event;
    logic [WORD_W-1:0] tick_q;
    logic [WORD_W-1:0] tick_d;
    logic [WORD_W-1:0] div_q;
    logic [WORD_W-1:0] display_q;
    logic              overflow_q;
    logic              irq_q;
    logic [WORD_W-1:0] sw_meta;
    logic [WORD_W-1:0] sw_sync;

    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic [WORD_W-1:0] status;
    logic [WORD_W-1:0] rdata;

    assign hit       = CS && (addr[ADDR_W-1:2] == BASE_A[ADDR_W-1:2]);
    assign off       = io_off_t'(addr[1:0]);
    assign wr_en     = hit && !R_NW;
    assign rd_en     = hit && R_NW;
    assign push      = wr_en && (off == IO_DATA);
    assign div_wr    = wr_en && (off == IO_DIV);
    assign status_rd = rd_en && (off == IO_STATUS);
    assign ovf_event = push && fifo_full && !pop;

    sync_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .din    (sysbus),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Drain pacing: the countdown restarts from DIV-1 whenever there is nothing
    // to show or a byte has just been shown, so a DIV write only affects the
    // next restart and never the countdown already in flight.
    always_comb begin
        pop    = 1'b0;
        tick_d = tick_q;
        if (!fifo_empty && (tick_q == '0)) begin
            pop = 1'b1;
        end
        if (pop || fifo_empty) begin
            tick_d = div_q - WORD_W'(1);
        end else begin
            tick_d = tick_q - WORD_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_q     <= WORD_W'(DIV_RST - 1);
            div_q      <= WORD_W'(DIV_RST);
            display_q  <= '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b1;
            sw_meta    <= '0;
            sw_sync    <= '0;
        end else begin
            tick_q  <= tick_d;
            irq_q   <= fifo_empty;
            sw_meta <= switches;
            sw_sync <= sw_meta;
            if (pop) begin
                display_q <= fifo_dout;
            end
            if (div_wr) begin
                div_q <= (sysbus == '0) ? WORD_W'(1) : sysbus;
            end
            // A fresh overflow on the same edge as a STATUS read keeps the flag.
            if (ovf_event) begin
                overflow_q <= 1'b1;
            end else if (status_rd) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        status                   = '0;
        status[STAT_OVF]         = overflow_q;
        status[STAT_FULL]        = fifo_full;
        status[STAT_EMPTY]       = fifo_empty;
        status[STAT_CNT_W-1:0]   = STAT_CNT_W'(fifo_count);
    end

    always_comb begin
        rdata = '0;
        case (off)
            IO_DATA:   rdata = display_q;
            IO_STATUS: rdata = status;
            IO_SW:     rdata = sw_sync;
            IO_DIV:    rdata = div_q;
            default:   rdata = '0;
        endcase
    end

    assign sysbus    = rd_en ? rdata : 'z;
    assign display   = display_q;
    assign irq_empty = irq_q;

endmodule

// File: tb/tb_bus_io_target.sv
// Self-checking bench for bus_io_target: reset/decode vector table, directed
// drain/overflow/reset sequences, then random bus traffic against a queue model.
module tb_bus_io_target;

    localparam logic [4:0] BASE_A = 5'h1C;

    logic       clock;
    logic       reset;
    logic       CS;
    logic       R_NW;
    logic [4:0] addr;
    logic [7:0] bus_drv;
    logic       bus_oe;
    logic [7:0] switches;
    logic [7:0] display;
    logic       irq_empty;
    tri1  [7:0] sysbus;

    assign sysbus = bus_oe ? bus_drv : 8'hzz;

    bus_io_target dut (
        .clock     (clock),
        .reset     (reset),
        .CS        (CS),
        .R_NW      (R_NW),
        .addr      (addr),
        .sysbus    (sysbus),
        .switches  (switches),
        .display   (display),
        .irq_empty (irq_empty)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int tests;
    int fails;

    // Behavioural model: a byte queue plus the absolute edge number of the
    // next permitted drain.
    logic [7:0] mq[$];
    longint     edge_n;
    longint     due;
    logic [7:0] m_div;
    logic [7:0] m_display;
    logic [7:0] m_sw1;
    logic [7:0] m_sw2;
    logic       m_ovf;
    logic       m_irq;

    typedef struct {
        logic       cs;
        logic       rnw;
        logic [4:0] a;
        logic [7:0] exp_bus;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic cs, input logic rnw, input logic [4:0] a, input logic [7:0] d);
        CS      = cs;
        R_NW    = rnw;
        addr    = a;
        bus_drv = d;
        bus_oe  = cs && !rnw;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b1, 5'h00, 8'h00);
    endtask

    task automatic modelStep();
        int pre;
        bit hit, wr, rd, push, do_pop, ovf_ev;
        edge_n++;
        if (reset) begin
            mq.delete();
            m_div     = 8'd8;
            due       = edge_n + 8;
            m_display = 8'h00;
            m_ovf     = 1'b0;
            m_irq     = 1'b1;
            m_sw1     = 8'h00;
            m_sw2     = 8'h00;
        end else begin
            hit    = CS && (addr[4:2] == 3'b111);
            wr     = hit && !R_NW;
            rd     = hit && R_NW;
            pre    = mq.size();
            do_pop = (edge_n == due) && (pre > 0);
            push   = wr && (addr[1:0] == 2'd0);
            ovf_ev = push && (pre == 4) && !do_pop;
            if (do_pop || pre == 0) due = edge_n + longint'(m_div);
            if (do_pop) m_display = mq.pop_front();
            if (push && !ovf_ev) mq.push_back(bus_drv);
            if (ovf_ev) m_ovf = 1'b1;
            else if (rd && addr[1:0] == 2'd1) m_ovf = 1'b0;
            if (wr && addr[1:0] == 2'd3) m_div = (bus_drv == 8'h00) ? 8'd1 : bus_drv;
            m_irq = (pre == 0);
            m_sw2 = m_sw1;
            m_sw1 = switches;
        end
    endtask

    function automatic logic [7:0] expRead(input logic [1:0] off);
        int n;
        n = mq.size();
        case (off)
            2'd0:    return m_display;
            2'd1:    return {m_ovf, n == 4, n == 0, 2'b00, 3'(n)};
            2'd2:    return m_sw2;
            default: return m_div;
        endcase
    endfunction

    task automatic nextEdge();
        modelStep();
        @(posedge clock);
        #1;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) nextEdge();
    endtask

    task automatic readReg(input logic [1:0] off, input logic [7:0] exp, input string name);
        applyStimulus(1'b1, 1'b1, BASE_A | 5'(off), 8'h00);
        #1;
        checkOutput(name, sysbus, exp);
        nextEdge();
        idle();
    endtask

    task automatic writeReg(input logic [1:0] off, input logic [7:0] d);
        applyStimulus(1'b1, 1'b0, BASE_A | 5'(off), d);
        nextEdge();
        idle();
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        edge_n   = 0;
        due      = 0;
        reset    = 1'b1;
        switches = 8'h81;
        idle();

        vecs[0] = '{1'b1, 1'b1, 5'h1C, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 5'h1D, 8'h20};
        vecs[2] = '{1'b1, 1'b1, 5'h1E, 8'h81};
        vecs[3] = '{1'b1, 1'b1, 5'h1F, 8'h08};
        vecs[4] = '{1'b0, 1'b1, 5'h1C, 8'hFF};
        vecs[5] = '{1'b1, 1'b1, 5'h1B, 8'hFF};
        vecs[6] = '{1'b1, 1'b1, 5'h00, 8'hFF};
        vecs[7] = '{1'b0, 1'b1, 5'h1F, 8'hFF};

        waitEdges(3);
        reset = 1'b0;
        checkOutput("reset_display", display, 8'h00);
        checkOutput("reset_irq", {7'b0, irq_empty}, 8'h01);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].cs, vecs[i].rnw, vecs[i].a, 8'h00);
            #1;
            checkOutput($sformatf("vec%0d_bus", i), sysbus, vecs[i].exp_bus);
            nextEdge();
            idle();
        end

        // First byte into an empty FIFO appears DIV edges after its write edge.
        writeReg(2'd0, 8'hA5);
        readReg(2'd1, 8'h01, "lat_status_cnt1");
        checkOutput("lat_irq_low", {7'b0, irq_empty}, 8'h00);
        waitEdges(6);
        checkOutput("lat_display_early", display, 8'h00);
        waitEdges(1);
        checkOutput("lat_display_on_time", display, 8'hA5);
        readReg(2'd1, 8'h20, "lat_status_cnt0");

        // Overflow with DIV=8, then DIV=2 written mid-countdown.
        for (int i = 1; i <= 5; i++) writeReg(2'd0, 8'(i));
        writeReg(2'd3, 8'h02);
        readReg(2'd1, 8'hC4, "ovf_status_set");
        readReg(2'd1, 8'h44, "ovf_status_cleared");
        checkOutput("ovf_display_hold", display, 8'hA5);
        waitEdges(1);
        checkOutput("drain_01", display, 8'h01);
        waitEdges(1);
        checkOutput("drain_01_hold", display, 8'h01);
        waitEdges(1);
        checkOutput("drain_02", display, 8'h02);
        waitEdges(2);
        checkOutput("drain_03", display, 8'h03);
        waitEdges(2);
        checkOutput("drain_04", display, 8'h04);
        waitEdges(4);
        readReg(2'd0, 8'h04, "drain_05_dropped");
        readReg(2'd1, 8'h20, "drain_status_empty");

        // Full FIFO: fifth push lands on the same edge as the first pop.
        writeReg(2'd3, 8'h04);
        for (int i = 0; i < 5; i++) writeReg(2'd0, 8'h11 + 8'(i));
        readReg(2'd1, 8'h44, "full_pushpop_status");
        checkOutput("full_pushpop_head", display, 8'h11);
        waitEdges(15);
        checkOutput("full_pushpop_last", display, 8'h15);

        // Switch synchroniser latency and a just-below-window address.
        switches = 8'h3C;
        readReg(2'd2, 8'h81, "sw_sync_edge0");
        readReg(2'd2, 8'h81, "sw_sync_edge1");
        readReg(2'd2, 8'h3C, "sw_sync_edge2");
        applyStimulus(1'b1, 1'b1, 5'h1B, 8'h00);
        #1;
        checkOutput("nonhit_bus_z", sysbus, 8'hFF);
        nextEdge();
        idle();

        // Reset with a full FIFO, overflow set and a pop due on the reset edge.
        writeReg(2'd3, 8'h03);
        for (int i = 0; i < 6; i++) writeReg(2'd0, 8'h21 + 8'(i));
        checkOutput("prereset_display", display, 8'h21);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, BASE_A, 8'h77);
        nextEdge();
        reset = 1'b0;
        idle();
        checkOutput("rst_display", display, 8'h00);
        checkOutput("rst_irq", {7'b0, irq_empty}, 8'h01);
        readReg(2'd1, 8'h20, "rst_status");
        readReg(2'd3, 8'h08, "rst_div");
        waitEdges(12);
        checkOutput("rst_no_pop", display, 8'h00);
        readReg(2'd1, 8'h20, "rst_write_lost");

        // Random bus traffic checked against the queue model.
        for (int i = 0; i < 600; i++) begin
            logic       cs, rnw;
            logic [1:0] off;
            logic [4:0] a;
            logic [7:0] d;
            int         kind;
            reset = ($urandom_range(0, 99) < 2);
            kind  = $urandom_range(0, 9);
            cs    = (kind != 0);
            rnw   = (kind <= 5);
            if (!rnw && $urandom_range(0, 4) < 3) off = 2'd0;
            else off = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 4) == 0) ? 5'($urandom) : (BASE_A | 5'(off));
            d = (a[1:0] == 2'd3) ? 8'($urandom_range(0, 5)) : 8'($urandom);
            if ($urandom_range(0, 3) == 0) switches = 8'($urandom);
            applyStimulus(cs, rnw, a, d);
            #1;
            if (cs && rnw && a[4:2] == 3'b111) checkOutput("rand_read", sysbus, expRead(a[1:0]));
            else if (!(cs && !rnw)) checkOutput("rand_bus_z", sysbus, 8'hFF);
            nextEdge();
            checkOutput("rand_display", display, m_display);
            checkOutput("rand_irq", {7'b0, irq_empty}, {7'b0, m_irq});
        end
        reset = 1'b0;
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
